// File: rtl/pc_sequencer.sv
// Next-PC controller: boot hold, sequential fetch, redirects, stall, EBREAK halt/resume, misaligned traps.
// Define PCSEQ_INSTRET_EN to build the 64-bit retired-instruction counter; otherwise instret reads zero.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int          BOOT_CYCLES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_current,
   output logic [31:0] pc_next,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        stall,
   input  logic        halt_req,
   input  logic        resume,
   output logic        pc_valid,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [31:0] mepc,
   output logic [63:0] instret
);

   // state | meaning
   // BOOT  | post-reset hold at RESET_VECTOR for BOOT_CYCLES cycles
   // RUN   | normal fetch: stall, halt, jump, branch, +4 in priority order
   // HALT  | EBREAK committed; PC frozen until resume
   // TRAP  | single cycle announcing a misaligned-target trap
   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2,
      TRAP = 2'd3
   } state_t;

   localparam logic [1:0] CAUSE_BRANCH = 2'd1;
   localparam logic [1:0] CAUSE_JUMP   = 2'd2;
   localparam logic [3:0] BOOT_LAST    = 4'(BOOT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  boot_cnt_q, boot_cnt_d;
   logic [31:0] mepc_q, mepc_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_current + 32'd4;

   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      mepc_d     = mepc_q;
      cause_d    = cause_q;
      pc_next    = pc_current;
      pc_valid   = 1'b0;
      trap       = 1'b0;
      if (rst) begin
         pc_next = RESET_VECTOR;
      end else begin
         unique case (state_q)
            BOOT: begin
               pc_next    = RESET_VECTOR;
               boot_cnt_d = boot_cnt_q + 4'd1;
               if (boot_cnt_q == BOOT_LAST) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (stall) begin
                  pc_next = pc_current;
               end else if (halt_req) begin
                  pc_valid = 1'b1;
                  state_d  = HALT;
               end else if (jump) begin
                  if (jump_target[1:0] != 2'b00) begin
                     pc_next = TRAP_VECTOR;
                     mepc_d  = pc_current;
                     cause_d = CAUSE_JUMP;
                     state_d = TRAP;
                  end else begin
                     pc_next  = jump_target;
                     pc_valid = 1'b1;
                  end
               end else if (branch_taken) begin
                  if (branch_target[1:0] != 2'b00) begin
                     pc_next = TRAP_VECTOR;
                     mepc_d  = pc_current;
                     cause_d = CAUSE_BRANCH;
                     state_d = TRAP;
                  end else begin
                     pc_next  = branch_target;
                     pc_valid = 1'b1;
                  end
               end else begin
                  pc_next  = pc_plus4;
                  pc_valid = 1'b1;
               end
            end
            HALT: begin
               // resume steps past the EBREAK rather than re-executing it
               if (resume) begin
                  pc_next = pc_plus4;
                  state_d = RUN;
               end
            end
            TRAP: begin
               trap    = 1'b1;
               pc_next = TRAP_VECTOR;
               state_d = RUN;
            end
            default: state_d = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         boot_cnt_q <= 4'd0;
         mepc_q     <= 32'd0;
         cause_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         mepc_q     <= mepc_d;
         cause_q    <= cause_d;
      end
   end

   assign mepc       = mepc_q;
   assign trap_cause = cause_q;

`ifdef PCSEQ_INSTRET_EN
   logic [63:0] instret_q, instret_d;

   assign instret_d = instret_q + {63'd0, pc_valid};

   always_ff @(posedge clk) begin
      if (rst) begin
         instret_q <= 64'd0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;
`else
   assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; the bench itself models the PC register (loads pc_next every edge).
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_reg;
   logic [31:0] pc_next;
   logic        branch_taken, jump, stall, halt_req, resume;
   logic [31:0] branch_target, jump_target;
   logic        pc_valid, trap;
   logic [1:0]  trap_cause;
   logic [31:0] mepc;
   logic [63:0] instret;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_instret = 64'd0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) pc_reg <= pc_next;

   pc_sequencer dut (
      .clk(clk), .rst(rst), .pc_current(pc_reg), .pc_next(pc_next),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .stall(stall),
      .halt_req(halt_req), .resume(resume), .pc_valid(pc_valid),
      .trap(trap), .trap_cause(trap_cause), .mepc(mepc), .instret(instret)
   );

   typedef struct {
      logic        rst, bt;
      logic [31:0] btgt;
      logic        j;
      logic [31:0] jtgt;
      logic        st, hr, rs;
      logic [31:0] e_pc, e_next;
      logic        e_valid, e_trap;
      logic [1:0]  e_cause;
      logic [31:0] e_mepc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic bt, logic [31:0] btgt, logic j, logic [31:0] jtgt,
                               logic st, logic hr, logic rs, logic [31:0] e_pc, logic [31:0] e_next,
                               logic e_valid, logic e_trap, logic [1:0] e_cause, logic [31:0] e_mepc);
      vec_t v;
      v.rst = r; v.bt = bt; v.btgt = btgt; v.j = j; v.jtgt = jtgt;
      v.st = st; v.hr = hr; v.rs = rs; v.e_pc = e_pc; v.e_next = e_next;
      v.e_valid = e_valid; v.e_trap = e_trap; v.e_cause = e_cause; v.e_mepc = e_mepc;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic bt, input logic [31:0] btgt, input logic j,
                        input logic [31:0] jtgt, input logic st, input logic hr, input logic rs);
      rst = r; branch_taken = bt; branch_target = btgt; jump = j; jump_target = jtgt;
      stall = st; halt_req = hr; resume = rs;
   endtask

   task automatic chk_instret(input int idx);
`ifdef PCSEQ_INSTRET_EN
      chk("instret", idx, instret, exp_instret);
`else
      chk("instret", idx, instret, 64'd0);
`endif
   endtask

   initial begin
      // rst, bt, btgt, j, jtgt, st, hr, rs | pc_cur, pc_next, valid, trap, cause, mepc
      vecs.push_back(mk(1,0,0,0,0,0,0,0, 32'h0,32'h0,0,0,0,32'h0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 32'h0,32'h0,0,0,0,32'h0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 32'h0,32'h0,0,0,0,32'h0));
      vecs.push_back(mk(0,0,0,0,0,0,0,1, 32'h0,32'h4,1,0,0,32'h0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 32'h4,32'h8,1,0,0,32'h0));
      vecs.push_back(mk(0,1,32'h80,1,32'h40,0,0,0, 32'h8,32'h40,1,0,0,32'h0));
      vecs.push_back(mk(0,1,32'h20,0,0,0,0,0, 32'h40,32'h20,1,0,0,32'h0));
      vecs.push_back(mk(0,0,0,1,32'h100,1,0,0, 32'h20,32'h20,0,0,0,32'h0));
      vecs.push_back(mk(0,0,0,1,32'h100,1,1,0, 32'h20,32'h20,0,0,0,32'h0));
      vecs.push_back(mk(0,0,0,1,32'h100,1,0,0, 32'h20,32'h20,0,0,0,32'h0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 32'h20,32'h24,1,0,0,32'h0));
      vecs.push_back(mk(0,0,0,1,32'h42,0,0,0, 32'h24,32'h100,0,0,0,32'h0));
      vecs.push_back(mk(0,0,0,1,32'h3,0,1,0, 32'h100,32'h100,0,1,2,32'h24));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 32'h100,32'h104,1,0,2,32'h24));
      vecs.push_back(mk(0,0,0,0,0,0,1,0, 32'h104,32'h104,1,0,2,32'h24));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 32'h104,32'h104,0,0,2,32'h24));
      vecs.push_back(mk(0,0,0,1,32'h200,1,0,0, 32'h104,32'h104,0,0,2,32'h24));
      vecs.push_back(mk(0,1,32'h300,0,0,0,1,0, 32'h104,32'h104,0,0,2,32'h24));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 32'h104,32'h104,0,0,2,32'h24));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 32'h104,32'h104,0,0,2,32'h24));
      vecs.push_back(mk(0,0,0,0,0,0,0,1, 32'h104,32'h108,0,0,2,32'h24));
      vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0,0,0,0, 32'h108,32'hFFFF_FFFC,1,0,2,32'h24));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 32'hFFFF_FFFC,32'h0,1,0,2,32'h24));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 32'h0,32'h4,1,0,2,32'h24));
      vecs.push_back(mk(0,1,32'h81,0,0,0,0,0, 32'h4,32'h100,0,0,2,32'h24));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 32'h100,32'h100,0,1,1,32'h4));
      vecs.push_back(mk(0,0,0,0,0,0,1,0, 32'h100,32'h100,1,0,1,32'h4));
      vecs.push_back(mk(1,0,0,0,0,0,0,0, 32'h100,32'h0,0,0,1,32'h4));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 32'h0,32'h0,0,0,0,32'h0));

      // first reset cycle: PC register contents are still unknown
      drive(1,0,0,0,0,0,0,0);
      @(negedge clk);
      chk("rst_pc_next", -1, pc_next, 32'h0);
      chk("rst_pc_valid", -1, pc_valid, 1'b0);
      chk("rst_trap", -1, trap, 1'b0);
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].bt, vecs[i].btgt, vecs[i].j, vecs[i].jtgt,
               vecs[i].st, vecs[i].hr, vecs[i].rs);
         @(negedge clk);
         chk("pc_current", i, pc_reg, vecs[i].e_pc);
         chk("pc_next", i, pc_next, vecs[i].e_next);
         chk("pc_valid", i, pc_valid, vecs[i].e_valid);
         chk("trap", i, trap, vecs[i].e_trap);
         chk("trap_cause", i, trap_cause, vecs[i].e_cause);
         chk("mepc", i, mepc, vecs[i].e_mepc);
         chk_instret(i);
         if (vecs[i].rst) exp_instret = 64'd0;
         else if (vecs[i].e_valid) exp_instret = exp_instret + 64'd1;
         @(posedge clk); #1;
      end

      // second BOOT cycle after the mid-HALT reset, then 10 commits and 3 stalls
      drive(0,0,0,0,0,0,0,0);
      @(negedge clk);
      chk("boot2_valid", 100, pc_valid, 1'b0);
      @(posedge clk); #1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("seq_pc", 200 + k, pc_reg, 32'(4 * k));
         chk("seq_valid", 200 + k, pc_valid, 1'b1);
         exp_instret = exp_instret + 64'd1;
         @(posedge clk); #1;
      end
      drive(0,0,0,0,0,1,0,0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_pc", 300 + k, pc_reg, 32'h28);
         chk("stall_valid", 300 + k, pc_valid, 1'b0);
         @(posedge clk); #1;
      end
      drive(0,0,0,0,0,0,0,0);
      @(negedge clk);
`ifdef PCSEQ_INSTRET_EN
      chk("instret_10", 400, instret, 64'd10);
`else
      chk("instret_off", 400, instret, 64'd0);
`endif
      chk_instret(401);
      chk("resume_pc", 402, pc_next, 32'h2C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the single-cycle RV32I core. It drives `program_counter.pc_input` and reads back `program_counter.pc_output`. It sequences boot, sequential fetch, branch/jump redirects, stalls, EBREAK halt/resume and misaligned-target traps. The PC register stays a plain load-every-edge register; all hold/redirect decisions live here.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded during reset and boot.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned-target trap.
- BOOT_CYCLES, 2, post-reset cycles held in BOOT before RUN; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_current  in  32  from `program_counter.pc_output`.
- pc_next  out  32  to `program_counter.pc_input`; combinational.
- branch_taken  in  1  conditional branch resolved taken this cycle.
- branch_target  in  32  branch destination.
- jump  in  1  JAL/JALR this cycle.
- jump_target  in  32  jump destination (JALR bit0 already cleared by the datapath).
- stall  in  1  current instruction not complete; freeze.
- halt_req  in  1  current instruction is EBREAK.
- resume  in  1  leave HALT.
- pc_valid  out  1  instruction at pc_current commits this cycle.
- trap  out  1  high for the single TRAP cycle.
- trap_cause  out  2  0 none, 1 misaligned branch, 2 misaligned jump; registered.
- mepc  out  32  PC of the faulting instruction; registered.
- instret  out  64  retired-instruction count (see Optional Feature).

Behaviour:
- States: BOOT, RUN, HALT, TRAP. Encoding is free.
- rst=1, any state, including mid-operation:
  - pc_next = RESET_VECTOR combinationally, so the PC register loads it on the same edge.
  - Next state BOOT; boot counter 0; mepc 0; trap_cause 0.
  - While rst=1: pc_valid=0, trap=0.
- BOOT:
  - pc_next = RESET_VECTOR; pc_valid=0.
  - Counter increments each cycle; after BOOT_CYCLES cycles in BOOT, next state is RUN.
- RUN, evaluated in priority order:
  1. stall=1: pc_next = pc_current; pc_valid=0; all other inputs ignored; stay in RUN.
  2. halt_req=1: pc_next = pc_current; pc_valid=1 (EBREAK commits); next state HALT.
  3. jump=1: if jump_target[1:0]≠0 → trap with cause 2, otherwise pc_next = jump_target. Jump wins over a simultaneous branch_taken.
  4. branch_taken=1: if branch_target[1:0]≠0 → trap with cause 1, otherwise pc_next = branch_target.
  5. Otherwise: pc_next = pc_current + 4, modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000, no flag).
  - Any non-stalled RUN cycle asserts pc_valid=1, except a trapping one.
- Trap entry (from RUN):
  - pc_next = TRAP_VECTOR; pc_valid=0.
  - mepc ← pc_current; trap_cause ← cause; next state TRAP.
- TRAP, exactly one cycle:
  - trap=1; pc_valid=0; pc_next = TRAP_VECTOR; next state RUN.
  - All inputs ignored.
  - mepc and trap_cause hold until the next trap or reset.
- HALT:
  - pc_next = pc_current; pc_valid=0.
  - resume=1: pc_next = pc_current + 4 (skips the EBREAK); next state RUN.
  - All other inputs are ignored.
- resume is ignored outside HALT. halt_req, redirects and stall are ignored outside RUN.
- No multicycle latency: a redirect decided in cycle N appears on pc_current in cycle N+1.

Optional Feature:
- Macro: PCSEQ_INSTRET_EN.
- Defined:
  - instret is a 64-bit register, cleared by rst.
  - It increments by 1 on every edge where pc_valid=1, with 64-bit wrap.
- Undefined:
  - instret is tied to 64'h0 and no counter logic is instantiated.
  - All other behaviour is identical.

Test Plan:
- Boot: rst=1 for 2 cycles, then 0 → pc_next=0x0 and pc_valid=0 for 2 cycles; RUN follows, pc_current 0x0, 0x4, 0x8 with pc_valid=1.
- Redirect priority: at pc=0x8, assert jump=1 (target 0x40) and branch_taken=1 (target 0x80) together → next pc=0x40. Then branch_taken=1 with target 0x20 → next pc=0x20.
- Stall: at pc=0x20, stall=1 for 3 cycles with jump=1 (target 0x100) → pc stays 0x20 and pc_valid=0. Release stall with no redirect → 0x24.
- Misaligned trap: at pc=0x24, jump=1 with target 0x42 → pc_current=0x100 next cycle with trap=1 for exactly 1 cycle, mepc=0x24, trap_cause=2; the following cycle runs at 0x100 with pc_valid=1.
- Halt/resume and wrap:
  - At pc=0x104, halt_req=1 → pc holds 0x104 for 5 cycles with resume=0. Assert resume=1 → 0x108.
  - Separately, force a branch to 0xFFFF_FFFC, then no redirect → 0x0.
- Reset mid-op and counter:
  - rst=1 while in HALT → next cycle pc=0x0, state BOOT, mepc=0, trap_cause=0.
  - With PCSEQ_INSTRET_EN defined, 10 committed instructions → instret=10; 3 stall cycles add 0.
